// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: round-robin arbiter of two masters onto RW port 0 and a read sequencer
// on R port 1 of a 1RW+1R SRAM macro, stalling port 1 while port 0 writes the same word.
module sram_1rw1r_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_rdata,
    output logic              r_ready,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [STRB_W-1:0] sram_wmask0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    input  logic [DATA_W-1:0] sram_dout0,
    output logic              sram_csb1,
    output logic [ADDR_W-1:0] sram_addr1,
    input  logic [DATA_W-1:0] sram_dout1
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;
    state_t p0_state, p1_state;
    logic rr, gnt, e0, e1, p0_go, p0_sel, hazard, p1_go;
    logic [ADDR_W-1:0] p0_addr_n;
    logic [DATA_W-1:0] p0_data_n;
    logic [STRB_W-1:0] p0_strb_n;
    always_comb begin
        e0        = m0_valid && !(p0_state == RSP && !gnt);
        e1        = m1_valid && !(p0_state == RSP && gnt);
        p0_go     = (p0_state != ACC) && (e0 || e1);
        p0_sel    = (e0 && e1) ? ~rr : e1;
        p0_addr_n = p0_sel ? m1_addr : m0_addr;
        p0_data_n = p0_sel ? m1_wdata : m0_wdata;
        p0_strb_n = p0_sel ? m1_wstrb : m0_wstrb;
        // port 1 must not sit in ACC alongside a port-0 write to the same word
        hazard    = p0_go && (p0_strb_n != '0) && (p0_addr_n == r_addr);
        p1_go     = (p1_state == IDLE) && r_valid && !hazard;
    end
    // web0 still holds the served op's direction during RSP
    assign m0_rdata = (m0_ready && sram_web0) ? sram_dout0 : '0;
    assign m1_rdata = (m1_ready && sram_web0) ? sram_dout0 : '0;
    assign r_rdata  = r_ready ? sram_dout1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_state    <= IDLE;
            rr          <= 1'b1;
            gnt         <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            if (p0_state == ACC) begin
                p0_state  <= RSP;
                sram_csb0 <= 1'b1;
                m0_ready  <= !gnt;
                m1_ready  <= gnt;
            end else if (p0_go) begin
                p0_state    <= ACC;
                gnt         <= p0_sel;
                rr          <= p0_sel;
                sram_csb0   <= 1'b0;
                sram_web0   <= (p0_strb_n == '0);
                sram_wmask0 <= p0_strb_n;
                sram_addr0  <= p0_addr_n;
                sram_din0   <= p0_data_n;
            end else begin
                p0_state <= IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_state   <= IDLE;
            sram_csb1  <= 1'b1;
            sram_addr1 <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (p1_state == ACC) begin
                p1_state  <= RSP;
                sram_csb1 <= 1'b1;
                r_ready   <= 1'b1;
            end else if (p1_go) begin
                p1_state   <= ACC;
                sram_csb1  <= 1'b0;
                sram_addr1 <= r_addr;
            end else begin
                p1_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb_sram_1rw1r_arbiter: directed and randomized checks of the arbiter against a
// transaction-level memory model, with a behavioural 1RW+1R macro attached.
module tb_sram_1rw1r_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic m0_valid, m1_valid, r_valid, m0_ready, m1_ready, r_ready;
    logic [8:0] m0_addr, m1_addr, r_addr, sram_addr0, sram_addr1;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, r_rdata, sram_din0, dout0, dout1;
    logic [3:0] m0_wstrb, m1_wstrb, sram_wmask0;
    logic sram_csb0, sram_web0, sram_csb1;
    int errs = 0, checks = 0, viol = 0;
    logic [31:0] ref_mem [512];
    logic [31:0] mem [512];
    logic mem_init = 1'b0;
    logic rdy [2];
    logic [31:0] rd [2];
    assign rdy[0] = m0_ready;
    assign rdy[1] = m1_ready;
    assign rd[0]  = m0_rdata;
    assign rd[1]  = m1_rdata;

    always #5 clk = ~clk;

    sram_1rw1r_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .r_valid(r_valid), .r_addr(r_addr), .r_rdata(r_rdata), .r_ready(r_ready),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(dout1)
    );

    function automatic logic [31:0] pat(int i);
        return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b+:8] = d[8*b+:8];
        return v;
    endfunction

    // behavioural macro: both ports register on the clock, read data appears after the edge
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            if (!sram_csb1) dout1 <= mem[sram_addr1];
            if (!sram_csb0 && sram_web0) dout0 <= mem[sram_addr0];
            for (int b = 0; b < 4; b++)
                if (!sram_csb0 && !sram_web0 && sram_wmask0[b]) mem[sram_addr0][8*b+:8] <= sram_din0[8*b+:8];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_csb0 && !sram_csb1 && !sram_web0 && sram_addr0 == sram_addr1) viol++;
            if (m0_ready && m1_ready) viol++;
            if ((!m0_ready && m0_rdata != 0) || (!m1_ready && m1_rdata != 0) || (!r_ready && r_rdata != 0)) viol++;
        end
    end

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, logic v, logic [8:0] a, logic [31:0] d, logic [3:0] s);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // one isolated master op; lat counts clock edges from request to ready
    task automatic m_op(int m, logic [8:0] a, logic [31:0] d, logic [3:0] s, output logic [31:0] q, output int lat);
        drive(m, 1'b1, a, d, s);
        lat = 0;
        do begin
            tick;
            lat++;
        end while (!rdy[m] && lat < 10);
        q = rd[m];
        if (rdy[m] && s != 0) ref_mem[a] = merge(ref_mem[a], d, s);
        drive(m, 1'b0, '0, '0, '0);
        tick;
    endtask

    initial begin
        logic [31:0] q, rq;
        int lat, c0, c1, mt, rt, n;
        logic [8:0] ra [3];
        logic [31:0] rw [3];
        logic [3:0] rs [3];
        int age [3];
        bit busy [3];
        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        r_valid = 1'b0;
        r_addr = '0;
        tick;
        tick;
        check("rst_csb0", sram_csb0, 1);
        check("rst_csb1", sram_csb1, 1);
        check("rst_web0", sram_web0, 1);
        check("rst_ports0", {sram_wmask0, sram_addr0, sram_din0}, 0);
        check("rst_addr1", sram_addr1, 0);
        check("rst_ready", {m0_ready, m1_ready, r_ready}, 0);
        rst_n = 1'b1;
        tick;

        m_op(0, 9'h010, 32'hDEADBEEF, 4'hF, q, lat);
        check("t1_wr_lat", lat, 2);
        check("t1_wr_rdata", q, 0);
        m_op(0, 9'h010, 0, 4'h0, q, lat);
        check("t1_rd_lat", lat, 2);
        check("t1_rd_data", q, 32'hDEADBEEF);

        m_op(1, 9'h010, 32'h0000AB00, 4'h2, q, lat);
        check("t2_wr_lat", lat, 2);
        m_op(1, 9'h010, 0, 4'h0, q, lat);
        check("t2_rd_lat", lat, 2);
        check("t2_rd_data", q, 32'hDEADABEF);

        do_reset;
        drive(0, 1'b1, 9'h020, 0, 4'h0);
        drive(1, 1'b1, 9'h021, 0, 4'h0);
        for (int t = 1; t <= 12; t++) begin
            tick;
            check($sformatf("t3_m0_ready_%0d", t), m0_ready, t % 4 == 2);
            check($sformatf("t3_m1_ready_%0d", t), m1_ready, t % 4 == 0);
            if (m0_ready) check("t3_m0_data", m0_rdata, ref_mem[9'h020]);
            if (m1_ready) check("t3_m1_data", m1_rdata, ref_mem[9'h021]);
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        tick;
        tick;

        c0 = 0; c1 = 0; mt = 0; rt = 0; rq = 0;
        drive(0, 1'b1, 9'h1FF, 32'h12345678, 4'hF);
        r_valid = 1'b1;
        r_addr = 9'h1FF;
        for (int t = 1; t <= 8; t++) begin
            tick;
            if (!sram_csb0 && c0 == 0) c0 = t;
            if (!sram_csb1 && c1 == 0) c1 = t;
            if (m0_ready) begin
                mt = t;
                ref_mem[9'h1FF] = 32'h12345678;
                drive(0, 1'b0, '0, '0, '0);
            end
            if (r_ready) begin
                rt = t;
                rq = r_rdata;
                r_valid = 1'b0;
            end
        end
        check("t4_csb0_cycle", c0, 1);
        check("t4_csb1_lag", c1 - c0, 1);
        check("t4_m0_lat", mt, 2);
        check("t4_r_lat", rt, 3);
        check("t4_r_data", rq, 32'h12345678);

        mt = 0; rt = 0; q = 0; rq = 0;
        drive(0, 1'b1, 9'h001, 0, 4'h0);
        r_valid = 1'b1;
        r_addr = 9'h000;
        for (int t = 1; t <= 6; t++) begin
            tick;
            if (m0_ready) begin
                mt = t;
                q = m0_rdata;
                drive(0, 1'b0, '0, '0, '0);
            end
            if (r_ready) begin
                rt = t;
                rq = r_rdata;
                r_valid = 1'b0;
            end
        end
        check("t5_m0_lat", mt, 2);
        check("t5_r_lat", rt, 2);
        check("t5_m0_data", q, ref_mem[9'h001]);
        check("t5_r_data", rq, ref_mem[9'h000]);

        drive(0, 1'b1, 9'h030, 32'hCAFEF00D, 4'hF);
        tick;
        check("t6_in_acc", sram_csb0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_csb0", sram_csb0, 1);
        check("t6_web0", sram_web0, 1);
        check("t6_ports0", {sram_wmask0, sram_addr0, sram_din0}, 0);
        check("t6_ready", {m0_ready, m1_ready, r_ready}, 0);
        drive(0, 1'b0, '0, '0, '0);
        tick;
        tick;
        rst_n = 1'b1;
        n = 0;
        for (int t = 0; t < 4; t++) begin
            tick;
            n += int'(m0_ready);
        end
        check("t6_no_ready", n, 0);
        m_op(0, 9'h030, 0, 4'h0, q, lat);
        check("t6_next_lat", lat, 2);
        check("t6_next_data", q, ref_mem[9'h030]);

        for (int i = 0; i < 3; i++) begin
            busy[i] = 0;
            age[i] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            tick;
            for (int i = 0; i < 3; i++) if (busy[i]) age[i]++;
            if (r_ready) begin
                check("rnd_r_spurious", busy[2], 1);
                check("rnd_r_data", r_rdata, ref_mem[ra[2]]);
                check("rnd_r_lat", age[2] <= 4, 1);
                busy[2] = 0;
                r_valid = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (rdy[m]) begin
                    check($sformatf("rnd_m%0d_spurious", m), busy[m], 1);
                    check($sformatf("rnd_m%0d_data", m), rd[m], rs[m] == 0 ? ref_mem[ra[m]] : 32'h0);
                    check($sformatf("rnd_m%0d_lat", m), age[m] <= 5, 1);
                    if (rs[m] != 0) ref_mem[ra[m]] = merge(ref_mem[ra[m]], rw[m], rs[m]);
                    busy[m] = 0;
                    drive(m, 1'b0, '0, '0, '0);
                end
            end
            if (c < 660) begin
                for (int i = 0; i < 3; i++) begin
                    if (!busy[i] && $urandom_range(0, 1) == 1) begin
                        ra[i] = 9'($urandom_range(0, 7));
                        rw[i] = $urandom;
                        rs[i] = (i == 2 || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                        age[i] = 0;
                        busy[i] = 1;
                        if (i == 2) begin
                            r_valid = 1'b1;
                            r_addr = ra[i];
                        end else begin
                            drive(i, 1'b1, ra[i], rw[i], rs[i]);
                        end
                    end
                end
            end
        end
        check("rnd_drained", {busy[0], busy[1], busy[2]}, 0);
        check("protocol_viol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
